// File: rtl/usbdev_iomux_filt.sv
// USB device pin mux: 2-flop rx sync, flip correction, per-bit glitch filter, timed override FSM.
// Latency: rx_sync_o 2 cycles, rx_o +FiltCycles when filtering, tx_o/ctl_o combinational; no backpressure.
module usbdev_iomux_clk_mux2 (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic sel_i,
  output logic clk_o
);
  // Behavioural model of the glitch-free mux cell; map to the library cell in implementation.
  assign clk_o = sel_i ? clk1_i : clk0_i;
endmodule

module usbdev_iomux_filt #(
  parameter int unsigned NumRx      = 4,
  parameter int unsigned FiltCycles = 4,
  parameter int unsigned TimerW     = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumRx-1:0]  rx_async_i,
  input  logic              filt_en_i,
  input  logic              pin_flip_i,
  output logic [NumRx-1:0]  rx_sync_o,
  output logic [NumRx-1:0]  rx_o,
  input  logic [4:0]        core_tx_i,
  input  logic [2:0]        core_ctl_i,
  input  logic [4:0]        ovr_tx_i,
  input  logic [2:0]        ovr_ctl_i,
  input  logic              ovr_en_i,
  input  logic              ovr_start_i,
  input  logic [TimerW-1:0] ovr_timeout_i,
  input  logic              ovr_clr_i,
  output logic [4:0]        tx_o,
  output logic [2:0]        ctl_o,
  output logic              ovr_active_o,
  output logic              ovr_expired_o
);
  localparam logic [3:0] FiltMax = 4'(FiltCycles);

  typedef enum logic [1:0] {StIdle, StActive, StExpired} ovr_state_e;

  logic [NumRx-1:0]      sync1_q, sync2_q, rx_flip;
  logic [NumRx-1:0]      prev_q, filt_q, filt_d;
  logic [NumRx-1:0][3:0] cnt_q, cnt_d;
  ovr_state_e            state_q;
  logic [TimerW-1:0]     timer_q;
  logic                  expired_q;
  logic [4:0]            tx_sel, tx_alt;
  logic [2:0]            ctl_sel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= rx_async_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    rx_flip = sync2_q;
    if (pin_flip_i) begin
      rx_flip[0] = sync2_q[1];
      rx_flip[1] = sync2_q[0];
      rx_flip[2] = ~sync2_q[2];
    end
  end
  assign rx_sync_o = rx_flip;

  // Filters always run so enabling them never exposes a stale value.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    for (int i = 0; i < int'(NumRx); i++) begin
      if (rx_flip[i] != prev_q[i])  cnt_d[i] = 4'd1;
      else if (cnt_q[i] == FiltMax) cnt_d[i] = cnt_q[i];
      else                          cnt_d[i] = cnt_q[i] + 4'd1;
      if (cnt_d[i] == FiltMax) filt_d[i] = rx_flip[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= rx_flip;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end
  assign rx_o = filt_en_i ? filt_q : rx_flip;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      expired_q <= 1'b0;
    end else if (ovr_clr_i) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      unique case (state_q)
        StActive: begin
          if (ovr_start_i) begin
            timer_q <= ovr_timeout_i;
          end else if (timer_q != '0) begin
            timer_q <= timer_q - TimerW'(1);
            if (timer_q == TimerW'(1)) begin
              state_q   <= StExpired;
              expired_q <= 1'b1;
            end
          end
        end
        default: begin
          if (ovr_start_i) begin
            state_q   <= StActive;
            timer_q   <= ovr_timeout_i;
            expired_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ovr_active_o  = ovr_en_i | (state_q == StActive);
  assign ovr_expired_o = expired_q;

  // Flip view of the selected drive: dp/dn swapped, d inverted.
  assign tx_alt = {tx_sel[4:3], ~tx_sel[2], tx_sel[0], tx_sel[1]};

  for (genvar b = 0; b < 5; b++) begin : g_tx
    usbdev_iomux_clk_mux2 u_src_mux (
      .clk0_i (core_tx_i[b]),
      .clk1_i (ovr_tx_i[b]),
      .sel_i  (ovr_active_o),
      .clk_o  (tx_sel[b])
    );
    usbdev_iomux_clk_mux2 u_flip_mux (
      .clk0_i (tx_sel[b]),
      .clk1_i (tx_alt[b]),
      .sel_i  (pin_flip_i),
      .clk_o  (tx_o[b])
    );
  end

  assign ctl_sel = ovr_active_o ? ovr_ctl_i : core_ctl_i;
  assign ctl_o   = pin_flip_i ? {ctl_sel[2], ctl_sel[0], ctl_sel[1]} : ctl_sel;
endmodule

// File: tb/tb_usbdev_iomux_filt.sv
// Bench for usbdev_iomux_filt: reset, flip, glitch filter, timed/zero/reloaded override, reset abort.
module tb_usbdev_iomux_filt;
  localparam int NumRx  = 4;
  localparam int TimerW = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NumRx-1:0]  rx_async_i;
  logic              filt_en_i, pin_flip_i;
  logic [NumRx-1:0]  rx_sync_o, rx_o;
  logic [4:0]        core_tx_i, ovr_tx_i, tx_o;
  logic [2:0]        core_ctl_i, ovr_ctl_i, ctl_o;
  logic              ovr_en_i, ovr_start_i, ovr_clr_i;
  logic [TimerW-1:0] ovr_timeout_i;
  logic              ovr_active_o, ovr_expired_o;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] e;

  usbdev_iomux_filt #(.NumRx(NumRx), .FiltCycles(4), .TimerW(TimerW)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rx_async_i    (rx_async_i),
    .filt_en_i     (filt_en_i),
    .pin_flip_i    (pin_flip_i),
    .rx_sync_o     (rx_sync_o),
    .rx_o          (rx_o),
    .core_tx_i     (core_tx_i),
    .core_ctl_i    (core_ctl_i),
    .ovr_tx_i      (ovr_tx_i),
    .ovr_ctl_i     (ovr_ctl_i),
    .ovr_en_i      (ovr_en_i),
    .ovr_start_i   (ovr_start_i),
    .ovr_timeout_i (ovr_timeout_i),
    .ovr_clr_i     (ovr_clr_i),
    .tx_o          (tx_o),
    .ctl_o         (ctl_o),
    .ovr_active_o  (ovr_active_o),
    .ovr_expired_o (ovr_expired_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [4:0] flip_tx(input logic [4:0] v);
    return {v[4:3], ~v[2], v[0], v[1]};
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0; rx_async_i = '0; filt_en_i = 1'b0; pin_flip_i = 1'b0;
    core_tx_i = 5'b01001; core_ctl_i = 3'b001; ovr_tx_i = 5'b10110; ovr_ctl_i = 3'b100;
    ovr_en_i = 1'b1; ovr_start_i = 1'b0; ovr_clr_i = 1'b0; ovr_timeout_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (ovr_active_o !== 1'b1) begin errors++; $display("FAIL rst_active_en got=%b exp=1", ovr_active_o); end
    checks++; if (ovr_expired_o !== 1'b0) begin errors++; $display("FAIL rst_expired got=%b exp=0", ovr_expired_o); end
    checks++; if (tx_o !== 5'b10110) begin errors++; $display("FAIL rst_tx_ovr got=%b exp=10110", tx_o); end
    checks++; if (rx_sync_o !== 4'b0000) begin errors++; $display("FAIL rst_rx_sync got=%b exp=0000", rx_sync_o); end
    checks++; if (rx_o !== 4'b0000) begin errors++; $display("FAIL rst_rx got=%b exp=0000", rx_o); end
    ovr_en_i = 1'b0;
    #1;
    checks++; if (ovr_active_o !== 1'b0) begin errors++; $display("FAIL rst_active_noen got=%b exp=0", ovr_active_o); end
    checks++; if (tx_o !== 5'b01001) begin errors++; $display("FAIL rst_tx_core got=%b exp=01001", tx_o); end
    step();
    rst_ni = 1'b1;
    repeat (6) step();
  endtask

  // Expected word: {rx_sync[3:0], tx[4:0], ctl[2:0]}
  task automatic test_pin_flip();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        pin_flip_i = 1'b1; core_tx_i = 5'b00101; core_ctl_i = 3'b001; rx_async_i = 4'b0001;
        exp_q.push_back({4'd0, 4'b0100, 5'b00010, 3'b010});
      end else if (k == 1) begin
        exp_q.push_back({4'd0, 4'b0100, 5'b00010, 3'b010});
      end else if (k == 2) begin
        exp_q.push_back({4'd0, 4'b0110, 5'b00010, 3'b010});
      end else begin
        pin_flip_i = 1'b0;
        exp_q.push_back({4'd0, 4'b0001, 5'b00101, 3'b001});
      end
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++; if (rx_sync_o !== e[11:8]) begin errors++; $display("FAIL flip_rx_sync k=%0d got=%b exp=%b", k, rx_sync_o, e[11:8]); end
      checks++; if (tx_o !== e[7:3]) begin errors++; $display("FAIL flip_tx k=%0d got=%b exp=%b", k, tx_o, e[7:3]); end
      checks++; if (ctl_o !== e[2:0]) begin errors++; $display("FAIL flip_ctl k=%0d got=%b exp=%b", k, ctl_o, e[2:0]); end
      step();
    end
    rx_async_i = '0;
    repeat (8) step();
  endtask

  // dp pulse of `width` async cycles; synced edge shows at k=2.
  task automatic test_glitch_filter(input int width, input logic en);
    logic es, er;
    filt_en_i = en;
    rx_async_i[0] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      es = (k >= 2) && (k < 2 + width);
      er = en ? ((width >= 4) && (k >= 6) && (k < 6 + width)) : es;
      exp_q.push_back({14'd0, es, er});
    end
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == width) rx_async_i[0] = 1'b0;
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++; if (rx_sync_o[0] !== e[1]) begin errors++; $display("FAIL filt_sync w=%0d k=%0d got=%b exp=%b", width, k, rx_sync_o[0], e[1]); end
      checks++; if (rx_o[0] !== e[0]) begin errors++; $display("FAIL filt_rx w=%0d en=%0b k=%0d got=%b exp=%b", width, en, k, rx_o[0], e[0]); end
    end
    step();
  endtask

  // Expected word: {active, expired, tx[4:0]}
  task automatic test_timed_override();
    core_tx_i = 5'b00100; ovr_tx_i = 5'b11011; pin_flip_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      logic a;
      a = (k >= 1) && (k <= 5);
      exp_q.push_back({9'd0, a, (k >= 6), a ? 5'b11011 : 5'b00100});
      if (k == 0) begin ovr_timeout_i = 16'd5; ovr_start_i = 1'b1; end
      if (k == 1) ovr_start_i = 1'b0;
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++; if (ovr_active_o !== e[6]) begin errors++; $display("FAIL timed_active k=%0d got=%b exp=%b", k, ovr_active_o, e[6]); end
      checks++; if (ovr_expired_o !== e[5]) begin errors++; $display("FAIL timed_expired k=%0d got=%b exp=%b", k, ovr_expired_o, e[5]); end
      checks++; if (tx_o !== e[4:0]) begin errors++; $display("FAIL timed_tx k=%0d got=%b exp=%b", k, tx_o, e[4:0]); end
      step();
    end
  endtask

  // Expected word: {active, expired}
  task automatic test_simultaneous();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({14'd0, 1'b0, (k == 0)});
      if (k == 0) begin ovr_timeout_i = 16'd5; ovr_start_i = 1'b1; ovr_clr_i = 1'b1; end
      if (k == 1) begin ovr_start_i = 1'b0; ovr_clr_i = 1'b0; end
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++; if (ovr_active_o !== e[1]) begin errors++; $display("FAIL clrwin_active k=%0d got=%b exp=%b", k, ovr_active_o, e[1]); end
      checks++; if (ovr_expired_o !== e[0]) begin errors++; $display("FAIL clrwin_expired k=%0d got=%b exp=%b", k, ovr_expired_o, e[0]); end
      step();
    end
    for (int k = 0; k < 18; k++) begin
      exp_q.push_back({14'd0, (k >= 1) && (k <= 15), (k >= 16)});
      if (k == 0) begin ovr_timeout_i = 16'd6; ovr_start_i = 1'b1; end
      if (k == 1) ovr_start_i = 1'b0;
      if (k == 5) begin ovr_timeout_i = 16'd10; ovr_start_i = 1'b1; end
      if (k == 6) ovr_start_i = 1'b0;
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++; if (ovr_active_o !== e[1]) begin errors++; $display("FAIL reload_active k=%0d got=%b exp=%b", k, ovr_active_o, e[1]); end
      checks++; if (ovr_expired_o !== e[0]) begin errors++; $display("FAIL reload_expired k=%0d got=%b exp=%b", k, ovr_expired_o, e[0]); end
      step();
    end
  endtask

  task automatic test_level_override_timer();
    ovr_en_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      exp_q.push_back({14'd0, 1'b1, (k == 0) || (k >= 4)});
      if (k == 0) begin ovr_timeout_i = 16'd3; ovr_start_i = 1'b1; end
      if (k == 1) ovr_start_i = 1'b0;
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++; if (ovr_active_o !== e[1]) begin errors++; $display("FAIL en_active k=%0d got=%b exp=%b", k, ovr_active_o, e[1]); end
      checks++; if (ovr_expired_o !== e[0]) begin errors++; $display("FAIL en_expired k=%0d got=%b exp=%b", k, ovr_expired_o, e[0]); end
      step();
    end
    ovr_en_i = 1'b0;
  endtask

  task automatic test_zero_timeout_reset();
    for (int k = 0; k < 1104; k++) begin
      exp_q.push_back({14'd0, (k >= 1) && (k <= 1100), (k == 0)});
      if (k == 0) begin ovr_timeout_i = 16'd0; ovr_start_i = 1'b1; end
      if (k == 1) ovr_start_i = 1'b0;
      if (k == 1100) ovr_clr_i = 1'b1;
      if (k == 1101) ovr_clr_i = 1'b0;
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++; if (ovr_active_o !== e[1]) begin errors++; $display("FAIL zero_active k=%0d got=%b exp=%b", k, ovr_active_o, e[1]); end
      checks++; if (ovr_expired_o !== e[0]) begin errors++; $display("FAIL zero_expired k=%0d got=%b exp=%b", k, ovr_expired_o, e[0]); end
      step();
    end
    pin_flip_i = 1'b1; core_tx_i = 5'b00101; ovr_tx_i = 5'b11010;
    ovr_timeout_i = 16'd0; ovr_start_i = 1'b1;
    step();
    ovr_start_i = 1'b0;
    step();
    checks++; if (ovr_active_o !== 1'b1) begin errors++; $display("FAIL mid_active got=%b exp=1", ovr_active_o); end
    checks++; if (tx_o !== flip_tx(5'b11010)) begin errors++; $display("FAIL mid_tx got=%b exp=%b", tx_o, flip_tx(5'b11010)); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (ovr_active_o !== 1'b0) begin errors++; $display("FAIL rstmid_active got=%b exp=0", ovr_active_o); end
    checks++; if (tx_o !== 5'b00010) begin errors++; $display("FAIL rstmid_tx got=%b exp=00010", tx_o); end
    ovr_en_i = 1'b1;
    #1;
    checks++; if (ovr_active_o !== 1'b1) begin errors++; $display("FAIL rstmid_en_active got=%b exp=1", ovr_active_o); end
    checks++; if (tx_o !== flip_tx(5'b11010)) begin errors++; $display("FAIL rstmid_en_tx got=%b exp=%b", tx_o, flip_tx(5'b11010)); end
    ovr_en_i = 1'b0;
    step();
    rst_ni = 1'b1;
    repeat (3) step();
    @(negedge clk_i);
    checks++; if (ovr_active_o !== 1'b0) begin errors++; $display("FAIL postrst_active got=%b exp=0", ovr_active_o); end
  endtask

  initial begin
    test_reset();
    test_pin_flip();
    test_glitch_filter(3, 1'b1);
    test_glitch_filter(4, 1'b1);
    test_glitch_filter(2, 1'b0);
    test_timed_override();
    test_simultaneous();
    test_level_override_timer();
    test_zero_timeout_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
